// File: rtl/loader_pkg.sv
// imem_loader shared types: FSM states and byte-packing constants.
// States CHECK/FAIL are only reached when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BCW = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    RUN,
    CHECK,
    FAIL
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master = stream source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int AW = 5
);

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  we,
    input  waddr,
    input  wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output we,
    output waddr,
    output wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Big-endian byte-to-word shift register with modulo-4 byte count.
// word_full flags the shift that completes a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BCW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift_en) begin
      cnt  <= cnt + 1'b1;
      word <= {word[23:0], byte_in};
    end
  end

  assign word_full = shift_en &&
    (cnt == BCW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into imem words, holds core in reset.
// LOADER_CHECKSUM_EN adds a 32-bit sum trailer check (CHECK/FAIL).
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic [AW:0]  nwords,
  imem_loader_if.slave bus,
  output logic         core_clearb,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t LAST = CHECK;
`else
  localparam state_t LAST = RUN;
`endif

  state_t        state;
  state_t        state_n;
  logic [AW:0]   n_q;
  logic [AW:0]   wcnt;
  logic [AW:0]   n_sat;
  logic          go;
  logic          acc;
  logic          pk_clear;
  logic          pk_full;
  logic          last_word;
  logic [31:0]   pk_word;
  logic [31:0]   word_in;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic          unused_hi;

  assign n_sat = (nwords > DMAX) ? DMAX : nwords;

  assign go = start &&
    (state == IDLE || state == RUN || state == FAIL);

  assign acc      = bus.in_valid && bus.in_ready;
  assign pk_clear = clear || go;

  // Word including the byte accepted this cycle.
  assign word_in   = {pk_word[23:0], bus.in_data};
  assign unused_hi = ^pk_word[31:24];

  assign last_word = (wcnt + 1'b1) == n_q;

  byte_packer u_pk (
    .clk       (clk),
    .clear     (pk_clear),
    .shift_en  (acc),
    .byte_in   (bus.in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clk) begin
    if (clear || go) begin
      sum <= '0;
    end else if (state == WRITE) begin
      sum <= sum + wdata_q;
    end
  end
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, RUN: begin
        if (go) state_n = (n_sat == '0) ? LAST : RECV;
      end
      RECV: begin
        if (pk_full) state_n = WRITE;
      end
      WRITE: begin
        state_n = last_word ? LAST : RECV;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (pk_full) state_n = (word_in == sum) ? RUN : FAIL;
      end
      FAIL: begin
        if (go) state_n = (n_sat == '0) ? LAST : RECV;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= IDLE;
      n_q     <= '0;
      wcnt    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      we_q  <= (state == RECV) && pk_full;
      if (go) begin
        n_q  <= n_sat;
        wcnt <= '0;
      end
      if ((state == RECV) && pk_full) begin
        waddr_q <= wcnt[AW-1:0];
        wdata_q <= word_in;
      end
      if (state == WRITE) wcnt <= wcnt + 1'b1;
    end
  end

  assign bus.in_ready = (state == RECV) || (state == CHECK);
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;

  assign busy = (state == RECV) || (state == WRITE) ||
                (state == CHECK);
  assign done        = (state == RUN);
  assign core_clearb = (state == RUN);

`ifdef LOADER_CHECKSUM_EN
  assign err = (state == FAIL);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an expected-write queue model.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [AW:0] nwords;
  logic        core_clearb;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .nwords      (nwords),
    .bus         (bus),
    .core_clearb (core_clearb),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;
  int nwr  = 0;
  int s_cyc;
  logic [AW+31:0] expq[$];
  logic [31:0]    words[$];
  logic [AW-1:0]  last_addr;
  logic [31:0]    last_data;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.we) begin
      logic [AW+31:0] e;
      nwr++;
      last_addr = bus.waddr;
      last_data = bus.wdata;
      check("ready_low_in_write", bus.in_ready, 0);
      if (expq.size() == 0) begin
        check("extra_write", expq.size(), 1);
      end else begin
        e = expq.pop_front();
        check("waddr", bus.waddr, e[AW+31:32]);
        check("wdata", bus.wdata, e[31:0]);
      end
    end
  end

  // Model: first min(n,DEPTH) words land at addresses 0,1,2...
  task automatic plan(input int n, output logic [31:0] s);
    int k;
    k = (n > DEPTH) ? DEPTH : n;
    s = '0;
    for (int i = 0; i < k; i++) begin
      expq.push_back({AW'(i), words[i]});
      s += words[i];
    end
  endtask

  task automatic do_reset();
    clear = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 clear = 1'b0;
    expq.delete();
    nwr = 0;
  endtask

  task automatic do_start(input int n);
    nwords = (AW+1)'(n);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (t == 50) check("byte_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], gap);
  endtask

  task automatic send_words(input int k, input int gap);
    for (int i = 0; i < k; i++) send_word(words[i], gap);
  endtask

  task automatic finish_load(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    send_word(s, 0);
`else
    if (s === 'x) $display("sum unknown");
`endif
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check("done_timeout", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    int dc;
    int lat;
    clear = 1'b1;
    start = 1'b0;
    nwords = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
      {bus.we, bus.waddr, bus.wdata, bus.in_ready,
       busy, done, core_clearb, err}, 0);
    @(posedge clk);
    #1 clear = 1'b0;

    // Basic two-word load at full rate
    words = '{32'h20080005, 32'h20090007};
    plan(2, s);
    do_start(2);
    send_words(2, 0);
    finish_load(s);
    wait_done(dc);
    lat = dc - s_cyc + 1;
`ifndef LOADER_CHECKSUM_EN
    check("basic_latency", lat, 11);
`endif
    check("basic_run", {done, core_clearb, busy}, 3'b110);
    check("basic_last_addr", last_addr, 1);
    check("basic_last_data", last_data, 32'h20090007);
    check("basic_drained", expq.size(), 0);

    // Same stream with 3-cycle gaps
    do_reset();
    plan(2, s);
    do_start(2);
    send_words(2, 3);
    finish_load(s);
    wait_done(dc);
    check("gap_writes", nwr, 2);
    check("gap_drained", expq.size(), 0);
    check("gap_run", {done, core_clearb}, 2'b11);

    // Zero-length load
    do_reset();
    plan(0, s);
    do_start(0);
    finish_load(s);
    @(negedge clk);
    check("zero_run", {done, core_clearb, busy}, 3'b110);
    repeat (5) @(negedge clk);
    check("zero_writes", nwr, 0);

    // Oversized request saturates to DEPTH
    do_reset();
    words.delete();
    for (int i = 0; i < DEPTH; i++)
      words.push_back({8'(i), 8'(i) ^ 8'h5a, 8'hc3, ~8'(i)});
    plan(40, s);
    do_start(40);
    send_words(DEPTH, 0);
    finish_load(s);
    wait_done(dc);
    lat = dc - s_cyc + 1;
`ifndef LOADER_CHECKSUM_EN
    check("sat_latency", lat, 161);
`endif
    check("sat_writes", nwr, 32);
    check("sat_last_addr", last_addr, 31);
    check("sat_drained", expq.size(), 0);

    // Clear in the middle of word 1
    do_reset();
    words = '{32'h0badf00d, 32'h12345678};
    plan(2, s);
    do_start(2);
    send_word(words[0], 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("mid_pending", expq.size(), 1);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_clear_outputs",
      {bus.we, bus.waddr, bus.wdata, bus.in_ready,
       busy, done, core_clearb, err}, 0);
    clear = 1'b0;
    expq.delete();
    nwr = 0;
    words = '{32'haabbccdd};
    plan(1, s);
    do_start(1);
    send_words(1, 0);
    finish_load(s);
    wait_done(dc);
    check("mid_new_word", last_data, 32'haabbccdd);
    check("mid_new_addr", last_addr, 0);
    check("mid_writes", nwr, 1);

    // Restart from RUN; start during RECV is ignored
    words = '{32'h11223344};
    plan(1, s);
    nwr = 0;
    do_start(1);
    @(negedge clk);
    check("restart_hold", {core_clearb, busy, done}, 3'b010);
    @(posedge clk);
    #1;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    nwords = 3;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    finish_load(s);
    wait_done(dc);
    check("restart_writes", nwr, 1);
    check("restart_data", last_data, 32'h11223344);
    check("restart_drained", expq.size(), 0);
    check("restart_run", core_clearb, 1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    words = '{32'h00000001, 32'h00000002};
    plan(2, s);
    do_start(2);
    send_words(2, 0);
    send_word(32'h00000003, 0);
    wait_done(dc);
    check("ck_pass", {done, err, core_clearb}, 3'b101);
    do_reset();
    plan(2, s);
    do_start(2);
    send_words(2, 0);
    send_word(32'h00000004, 0);
    repeat (3) @(negedge clk);
    check("ck_fail", {done, err, core_clearb}, 3'b010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
